// File: rtl/bist_pkg.sv
// bist_pkg: shared encodings and defaults for the memory BIST controller and datapath.
package bist_pkg;
  typedef enum logic [2:0] {RST, W0, R0, W1, R1} bist_state_e;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
endpackage

// File: rtl/bist_datapath_if.sv
// bist_datapath_if: memory-under-test bus between the BIST datapath and the memory.
interface bist_datapath_if
  import bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              mem_re;
  modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/bist_rd_pipe.sv
// bist_rd_pipe: RD_LAT-deep shift register of {valid, expected word, address} with sync flush.
module bist_rd_pipe
  import bist_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_exp,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_exp,
  output logic [ADDR_W-1:0] out_addr
);
  logic [RD_LAT-1:0]             valid_q, valid_d;
  logic [RD_LAT-1:0][DATA_W-1:0] exp_q, exp_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_q, addr_d;
  // Truncating {stages, input} to the pipe width drops the oldest stage, which also covers RD_LAT=1.
  always_comb begin
    valid_d = flush ? '0 : RD_LAT'({valid_q, in_valid});
    exp_d   = (RD_LAT*DATA_W)'({exp_q, in_exp});
    addr_d  = (RD_LAT*ADDR_W)'({addr_q, in_addr});
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      exp_q   <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      exp_q   <= exp_d;
      addr_q  <= addr_d;
    end
  end
  assign out_valid = valid_q[RD_LAT-1];
  assign out_exp   = exp_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];
endmodule

// File: rtl/bist_datapath.sv
// bist_datapath: march-test address/data generation, delayed read compare and error log.
module bist_datapath
  import bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset,
  input  logic              preset,
  input  logic              en,
  input  logic              up_down,
  input  logic              out,
  input  logic              read,
  input  logic              write,
  bist_datapath_if.master   mem,
  output logic              carry,
  output logic              is_equal,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W+1:0] err_count
);
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("bist_datapath: RD_LAT=%0d outside supported range", RD_LAT);
  end
  logic [ADDR_W-1:0] cnt_q, cnt_d, err_addr_q, err_addr_d, pipe_addr;
  logic [ADDR_W+1:0] err_count_q, err_count_d;
  logic [DATA_W-1:0] pipe_exp;
  logic              err_flag_q, err_flag_d, pipe_valid, miss;
  // Descending order is the bitwise complement of the count, so one counter serves both directions.
  assign mem.mem_addr  = up_down ? cnt_q : ~cnt_q;
  assign mem.mem_wdata = {DATA_W{out}};
  assign mem.mem_we    = en && write;
  assign mem.mem_re    = en && read && !write;
  bist_rd_pipe #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (reset),
    .in_valid  (mem.mem_re),
    .in_exp    (mem.mem_wdata),
    .in_addr   (mem.mem_addr),
    .out_valid (pipe_valid),
    .out_exp   (pipe_exp),
    .out_addr  (pipe_addr)
  );
  always_comb begin
    carry       = en && (&cnt_q);
    miss        = pipe_valid && (mem.mem_rdata != pipe_exp);
    is_equal    = !miss;
    cnt_d       = reset ? '0 : preset ? '1 : en ? cnt_q + 1'b1 : cnt_q;
    err_flag_d  = !reset && (err_flag_q || miss);
    err_addr_d  = reset ? '0 : (miss && !err_flag_q) ? pipe_addr : err_addr_q;
    err_count_d = reset ? '0 : (miss && !(&err_count_q)) ? err_count_q + 1'b1 : err_count_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end
  assign err_flag  = err_flag_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_bist_datapath.sv
// tb_bist_datapath: directed march passes, fault injection and reset scenarios for bist_datapath.
module tb_bist_datapath;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LAT = 2;
  logic clk = 0, rst = 0, reset = 0, preset = 0, en = 0, up_down = 1, out = 0, read = 0, write = 0;
  logic carry, is_equal, err_flag;
  logic [AW-1:0] err_addr;
  logic [AW+1:0] err_count;
  logic [DW-1:0] mem [16] = '{default: '0};
  logic [DW-1:0] rdp0 = '0, rdp1 = '0;
  logic [15:0] stuck = '0;
  int cmp = 0, bad = 0;

  bist_datapath_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bist_datapath #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .reset(reset), .preset(preset), .en(en), .up_down(up_down),
    .out(out), .read(read), .write(write), .mem(bus.master), .carry(carry),
    .is_equal(is_equal), .err_flag(err_flag), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Memory model with RD_LAT=2 read latency; stuck addresses always return 0x01.
  assign bus.mem_rdata = rdp1;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rdp0 <= stuck[bus.mem_addr] ? 8'h01 : mem[bus.mem_addr];
    rdp1 <= rdp0;
  end

  task automatic pulse_reset();
    @(negedge clk);
    en = 0; read = 0; write = 0; preset = 0; reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    #2;
    cmp++; if (carry !== 1'b0) begin bad++; $display("FAIL rst_carry: got %b want 0", carry); end
    cmp++; if (is_equal !== 1'b1) begin bad++; $display("FAIL rst_is_equal: got %b want 1", is_equal); end
    cmp++; if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin bad++; $display("FAIL rst_strobes: got we=%b re=%b want 0 0", bus.mem_we, bus.mem_re); end
    cmp++; if (bus.mem_addr !== 4'd0) begin bad++; $display("FAIL rst_addr_up: got %0d want 0", bus.mem_addr); end
    cmp++; if (err_flag !== 1'b0 || err_addr !== 4'd0 || err_count !== 6'd0) begin bad++; $display("FAIL rst_log: got %b %0d %0d want 0 0 0", err_flag, err_addr, err_count); end
    up_down = 0; #1;
    cmp++; if (bus.mem_addr !== 4'd15) begin bad++; $display("FAIL rst_addr_down: got %0d want 15", bus.mem_addr); end
    up_down = 1;
    @(negedge clk); rst = 1;
  endtask

  task automatic test_march();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); en = 1; up_down = 1; write = 1; read = 0; out = 0; #1;
      cmp++; if (bus.mem_addr !== 4'(i)) begin bad++; $display("FAIL w0_addr[%0d]: got %0d want %0d", i, bus.mem_addr, i); end
      cmp++; if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_wdata !== 8'h00) begin bad++; $display("FAIL w0_strobe[%0d]: got we=%b re=%b wd=%h want 1 0 00", i, bus.mem_we, bus.mem_re, bus.mem_wdata); end
      cmp++; if (carry !== (i == 15)) begin bad++; $display("FAIL w0_carry[%0d]: got %b want %b", i, carry, i == 15); end
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); up_down = 0; write = 0; read = 1; #1;
      cmp++; if (bus.mem_addr !== 4'(15 - i)) begin bad++; $display("FAIL r0_addr[%0d]: got %0d want %0d", i, bus.mem_addr, 15 - i); end
      cmp++; if (bus.mem_re !== 1'b1 || carry !== (i == 15)) begin bad++; $display("FAIL r0_re_carry[%0d]: got re=%b carry=%b want 1 %b", i, bus.mem_re, carry, i == 15); end
      cmp++; if (is_equal !== 1'b1) begin bad++; $display("FAIL r0_eq[%0d]: got %b want 1", i, is_equal); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); en = 0; read = 0; #1;
      cmp++; if (is_equal !== 1'b1 || carry !== 1'b0) begin bad++; $display("FAIL r0_drain[%0d]: got eq=%b carry=%b want 1 0", i, is_equal, carry); end
    end
    cmp++; if (err_flag !== 1'b0 || err_count !== 6'd0) begin bad++; $display("FAIL march_log: got flag=%b cnt=%0d want 0 0", err_flag, err_count); end
  endtask

  task automatic test_single_fault();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); en = 1; up_down = 1; write = 1; read = 0; out = 1;
    end
    stuck = '0; stuck[5] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); en = (i < 16); write = 0; read = (i < 16); #1;
      cmp++; if (is_equal !== (i != 7)) begin bad++; $display("FAIL r1_eq[%0d]: got %b want %b", i, is_equal, i != 7); end
      if (i == 8) begin
        cmp++; if (err_flag !== 1'b1) begin bad++; $display("FAIL r1_flag_edge: got %b want 1", err_flag); end
      end
    end
    cmp++; if (err_flag !== 1'b1 || err_addr !== 4'd5 || err_count !== 6'd1) begin bad++; $display("FAIL single_log: got flag=%b addr=%0d cnt=%0d want 1 5 1", err_flag, err_addr, err_count); end
  endtask

  task automatic test_double_fault();
    stuck = '0; stuck[3] = 1'b1; stuck[9] = 1'b1;
    pulse_reset();
    #1;
    cmp++; if (err_flag !== 1'b0 || err_addr !== 4'd0 || err_count !== 6'd0) begin bad++; $display("FAIL clear_log: got flag=%b addr=%0d cnt=%0d want 0 0 0", err_flag, err_addr, err_count); end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); en = (i < 16); read = (i < 16); write = 0; up_down = 1; out = 1;
    end
    #1;
    cmp++; if (err_addr !== 4'd3 || err_count !== 6'd2) begin bad++; $display("FAIL double_log: got addr=%0d cnt=%0d want 3 2", err_addr, err_count); end
  endtask

  task automatic test_rw_conflict();
    @(negedge clk); en = 1; read = 1; write = 1; out = 1; #1;
    cmp++; if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0) begin bad++; $display("FAIL rw_conflict: got we=%b re=%b want 1 0", bus.mem_we, bus.mem_re); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); en = 0; read = 0; write = 0; #1;
      cmp++; if (is_equal !== 1'b1) begin bad++; $display("FAIL rw_no_compare[%0d]: got %b want 1", i, is_equal); end
    end
  endtask

  task automatic test_reset_clear();
    stuck = '0;
    pulse_reset();
    @(negedge clk); en = 1; read = 1; write = 0; out = 0; up_down = 1;
    @(negedge clk); en = 0; read = 0;
    @(negedge clk); #1;
    cmp++; if (is_equal !== 1'b0) begin bad++; $display("FAIL clr_pending_miss: got %b want 0", is_equal); end
    reset = 1;
    @(negedge clk); reset = 0; #1;
    cmp++; if (err_flag !== 1'b0 || err_count !== 6'd0 || is_equal !== 1'b1) begin bad++; $display("FAIL clr_wins: got flag=%b cnt=%0d eq=%b want 0 0 1", err_flag, err_count, is_equal); end
  endtask

  task automatic test_saturate();
    pulse_reset();
    for (int i = 0; i < 72; i++) begin
      @(negedge clk); en = (i < 70); read = (i < 70); write = 0; out = 0; up_down = 1; #1;
      if (i == 10) begin
        cmp++; if (err_count !== 6'd8) begin bad++; $display("FAIL sat_mid: got %0d want 8", err_count); end
      end
    end
    @(negedge clk); #1;
    cmp++; if (err_count !== 6'd63 || err_flag !== 1'b1 || err_addr !== 4'd0) begin bad++; $display("FAIL sat_end: got cnt=%0d flag=%b addr=%0d want 63 1 0", err_count, err_flag, err_addr); end
  endtask

  task automatic test_preset();
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); en = 1; read = 0; write = 0; up_down = 1;
    end
    @(negedge clk); preset = 1; en = 1; #1;
    cmp++; if (carry !== 1'b0 || bus.mem_addr !== 4'd4) begin bad++; $display("FAIL preset_cycle: got carry=%b addr=%0d want 0 4", carry, bus.mem_addr); end
    @(negedge clk); preset = 0; en = 1; #1;
    cmp++; if (carry !== 1'b1 || bus.mem_addr !== 4'd15) begin bad++; $display("FAIL preset_carry: got carry=%b addr=%0d want 1 15", carry, bus.mem_addr); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); en = 0; #1;
      cmp++; if (carry !== 1'b0 || bus.mem_addr !== 4'd0) begin bad++; $display("FAIL preset_wrap_hold[%0d]: got carry=%b addr=%0d want 0 0", i, carry, bus.mem_addr); end
    end
  endtask

  task automatic test_reset_midpass();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); en = 1; up_down = 1;
    end
    @(negedge clk); reset = 1; en = 1; #1;
    cmp++; if (bus.mem_addr !== 4'd6) begin bad++; $display("FAIL mid_before: got %0d want 6", bus.mem_addr); end
    @(negedge clk); reset = 0; #1;
    cmp++; if (bus.mem_addr !== 4'd0 || carry !== 1'b0) begin bad++; $display("FAIL mid_restart: got addr=%0d carry=%b want 0 0", bus.mem_addr, carry); end
    en = 0;
  endtask

  task automatic test_async_rst();
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); en = 1; read = 1; write = 0; out = 0; up_down = 1;
    end
    @(negedge clk); en = 0; read = 0; #1;
    cmp++; if (is_equal !== 1'b0 || err_count !== 6'd5 || bus.mem_addr !== 4'd7) begin bad++; $display("FAIL arst_before: got eq=%b cnt=%0d addr=%0d want 0 5 7", is_equal, err_count, bus.mem_addr); end
    #2 rst = 0; #1;
    cmp++; if (err_flag !== 1'b0 || err_addr !== 4'd0 || err_count !== 6'd0) begin bad++; $display("FAIL arst_log: got flag=%b addr=%0d cnt=%0d want 0 0 0", err_flag, err_addr, err_count); end
    cmp++; if (is_equal !== 1'b1 || bus.mem_addr !== 4'd0) begin bad++; $display("FAIL arst_pipe_cnt: got eq=%b addr=%0d want 1 0", is_equal, bus.mem_addr); end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      cmp++; if (err_flag !== 1'b0 || is_equal !== 1'b1) begin bad++; $display("FAIL arst_release[%0d]: got flag=%b eq=%b want 0 1", i, err_flag, is_equal); end
    end
  endtask

  initial begin
    test_reset();
    test_march();
    test_single_fault();
    test_double_fault();
    test_rw_conflict();
    test_reset_clear();
    test_saturate();
    test_preset();
    test_reset_midpass();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
